// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a CPU write to DMA_REG_ADDR halts the CPU and copies one 256-byte
// page from source memory into the PPU OAMDATA register, one read/write pair per byte.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_SEL  = 3'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_WE,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] mem_addr,
  output logic        mem_RE,
  input  logic [7:0]  mem_data,
  output logic        ppu_cs,
  output logic [2:0]  ppu_reg_addr,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_WE
);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       odd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      odd_q   <= ~odd_q;
    end
  end

  assign ppu_data_out = data_q;

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    data_d       = data_q;
    cpu_rdy      = 1'b0;
    dma_active   = 1'b1;
    mem_addr     = 16'h0000;
    mem_RE       = 1'b0;
    ppu_cs       = 1'b1;
    ppu_WE       = 1'b0;
    ppu_reg_addr = 3'd0;

    case (state_q)
      StIdle: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        if (cpu_WE && (cpu_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_data_in;
          idx_d   = 8'h00;
          state_d = StHalt;
        end
      end
      // Odd-cycle starts burn one extra cycle so reads always land on the same parity.
      StHalt:  state_d = odd_q ? StAlign : StRead;
      StAlign: state_d = StRead;
      StRead: begin
        mem_addr = {page_q, idx_q};
        mem_RE   = 1'b1;
        data_d   = mem_data;
        state_d  = StWrite;
      end
      StWrite: begin
        ppu_cs       = 1'b0;
        ppu_WE       = 1'b1;
        ppu_reg_addr = OAMDATA_SEL;
        idx_d        = idx_q + 8'd1;
        state_d      = (idx_q == 8'hFF) ? StIdle : StRead;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: table of whole-page transfers plus hand-written
// corner sequences (non-DMA write in idle, reset mid-transfer, retrigger).
module tb_oam_dma;

  localparam logic [15:0] DmaAddr = 16'h4014;
  localparam int          Bound   = 700;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_in = 8'h00;
  logic        cpu_WE = 1'b0;
  logic        cpu_rdy, dma_active, mem_RE, ppu_cs, ppu_WE;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, ppu_data_out;
  logic [2:0]  ppu_reg_addr;
  logic        par_q;

  int n_checks = 0;
  int n_pass   = 0;

  oam_dma dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_WE       (cpu_WE),
    .cpu_rdy      (cpu_rdy),
    .dma_active   (dma_active),
    .mem_addr     (mem_addr),
    .mem_RE       (mem_RE),
    .mem_data     (mem_data),
    .ppu_cs       (ppu_cs),
    .ppu_reg_addr (ppu_reg_addr),
    .ppu_data_out (ppu_data_out),
    .ppu_WE       (ppu_WE)
  );

  always #5 clk = ~clk;

  // Source memory: byte = addr[7:0] ^ 8'hA5, combinational.
  assign mem_data = mem_addr[7:0] ^ 8'hA5;

  // Independent parity model: toggles every clock from reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= ~par_q;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  page;
    bit          halt_odd;
    bit          rewrite;
    int          exp_low;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  // Triggers one transfer and observes it (sampling at negedge) until cpu_rdy returns.
  task automatic run_xfer(input logic [7:0] pg, input bit halt_odd, input bit rewrite,
                          output int low, output int edges, output int align_cyc,
                          output int rd_n, output int addr_err, output int data_err,
                          output int wr_err, output logic [15:0] first,
                          output logic [15:0] last, output bit timeout);
    int   cyc;
    int   wr_n;
    logic prev_cs;
    low = 0; edges = 0; align_cyc = 0; rd_n = 0; addr_err = 0; data_err = 0; wr_err = 0;
    first = 16'hxxxx; last = 16'hxxxx; wr_n = 0; cyc = 0; prev_cs = 1'b1;
    @(negedge clk);
    // The parity seen in HALT is the inverse of the trigger cycle's parity.
    while (par_q == halt_odd) @(negedge clk);
    cpu_addr = DmaAddr; cpu_data_in = pg; cpu_WE = 1'b1;
    @(negedge clk);
    cpu_WE = 1'b0; cpu_addr = 16'h0000;
    while (!cpu_rdy && cyc < Bound) begin
      low++;
      if (mem_RE) begin
        if (rd_n == 0) first = mem_addr;
        last = mem_addr;
        if (mem_addr != {pg, rd_n[7:0]}) addr_err++;
        rd_n++;
      end else if (!ppu_WE) begin
        align_cyc++;
      end
      if (ppu_WE) begin
        if (ppu_cs || ppu_reg_addr != 3'd4 || mem_RE) wr_err++;
        if (ppu_data_out != (wr_n[7:0] ^ 8'hA5)) data_err++;
        wr_n++;
      end else if (!ppu_cs) begin
        wr_err++;
      end
      if (prev_cs && !ppu_cs) edges++;
      prev_cs = ppu_cs;
      // Stray DMA write with a different page while busy, during the WRITE of idx 100.
      if (rewrite && mem_RE && mem_addr[7:0] == 8'd100) begin
        cpu_WE = 1'b1; cpu_addr = DmaAddr; cpu_data_in = 8'h07;
      end else begin
        cpu_WE = 1'b0; cpu_addr = 16'h0000;
      end
      @(negedge clk);
      cyc++;
    end
    cpu_WE = 1'b0;
    timeout = (cyc >= Bound);
  endtask

  initial begin
    vec_t        vecs[5];
    int          low, edges, align_cyc, rd_n, addr_err, data_err, wr_err, cyc, late_wr;
    logic [15:0] first, last;
    bit          timeout;

    vecs[0] = '{page: 8'h02, halt_odd: 1'b0, rewrite: 1'b0, exp_low: 513,
                exp_first: 16'h0200, exp_last: 16'h02FF};
    vecs[1] = '{page: 8'h02, halt_odd: 1'b1, rewrite: 1'b0, exp_low: 514,
                exp_first: 16'h0200, exp_last: 16'h02FF};
    vecs[2] = '{page: 8'h02, halt_odd: 1'b0, rewrite: 1'b1, exp_low: 513,
                exp_first: 16'h0200, exp_last: 16'h02FF};
    vecs[3] = '{page: 8'hFF, halt_odd: 1'b0, rewrite: 1'b0, exp_low: 513,
                exp_first: 16'hFF00, exp_last: 16'hFFFF};
    vecs[4] = '{page: 8'h00, halt_odd: 1'b1, rewrite: 1'b0, exp_low: 514,
                exp_first: 16'h0000, exp_last: 16'h00FF};

    #12;
    chk("reset_cpu_rdy", cpu_rdy, 1'b1);
    chk("reset_dma_active", dma_active, 1'b0);
    chk("reset_ppu_cs", ppu_cs, 1'b1);
    chk("reset_ppu_we", ppu_WE, 1'b0);
    chk("reset_mem_re", mem_RE, 1'b0);
    chk("reset_mem_addr", mem_addr, 16'h0000);
    chk("reset_ppu_regs", {ppu_reg_addr, ppu_data_out}, 11'h000);
    @(negedge clk);
    reset = 1'b1;

    // A write to a neighbouring register must not start a transfer.
    @(negedge clk);
    cpu_addr = 16'h4015; cpu_data_in = 8'h02; cpu_WE = 1'b1;
    @(negedge clk);
    cpu_WE = 1'b0; cpu_addr = 16'h0000;
    chk("no_trigger_active", dma_active, 1'b0);
    chk("no_trigger_rdy", cpu_rdy, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].page, vecs[i].halt_odd, vecs[i].rewrite, low, edges, align_cyc,
               rd_n, addr_err, data_err, wr_err, first, last, timeout);
      chk($sformatf("v%0d_timeout", i), timeout, 1'b0);
      chk($sformatf("v%0d_rdy_low", i), low, vecs[i].exp_low);
      chk($sformatf("v%0d_halt_align", i), align_cyc, 1 + vecs[i].halt_odd);
      chk($sformatf("v%0d_reads", i), rd_n, 256);
      chk($sformatf("v%0d_cs_edges", i), edges, 256);
      chk($sformatf("v%0d_first_addr", i), first, vecs[i].exp_first);
      chk($sformatf("v%0d_last_addr", i), last, vecs[i].exp_last);
      chk($sformatf("v%0d_addr_err", i), addr_err, 0);
      chk($sformatf("v%0d_data_err", i), data_err, 0);
      chk($sformatf("v%0d_wr_err", i), wr_err, 0);
      chk($sformatf("v%0d_idle_after", i), {cpu_rdy, dma_active, ppu_cs, mem_RE}, 4'b1010);
      chk($sformatf("v%0d_idle_addr", i), mem_addr, 16'h0000);
    end

    // Reset in the middle of a transfer, at the read of idx 50.
    @(negedge clk);
    cpu_addr = DmaAddr; cpu_data_in = 8'h02; cpu_WE = 1'b1;
    @(negedge clk);
    cpu_WE = 1'b0; cpu_addr = 16'h0000;
    cyc = 0;
    while (!(mem_RE && mem_addr == 16'h0232) && cyc < Bound) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reset_reached_idx50", cyc < Bound, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_reset_rdy", cpu_rdy, 1'b1);
    chk("mid_reset_cs", ppu_cs, 1'b1);
    chk("mid_reset_active", dma_active, 1'b0);
    chk("mid_reset_mem_re", mem_RE, 1'b0);
    chk("mid_reset_data", ppu_data_out, 8'h00);
    late_wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ppu_WE || !ppu_cs) late_wr++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ppu_WE || !ppu_cs || dma_active) late_wr++;
    end
    chk("mid_reset_no_write", late_wr, 0);

    run_xfer(8'h03, 1'b0, 1'b0, low, edges, align_cyc, rd_n, addr_err, data_err, wr_err,
             first, last, timeout);
    chk("retrig_timeout", timeout, 1'b0);
    chk("retrig_first_addr", first, 16'h0300);
    chk("retrig_last_addr", last, 16'h03FF);
    chk("retrig_cs_edges", edges, 256);
    chk("retrig_errs", addr_err + data_err + wr_err, 0);
    chk("retrig_rdy_low", low, 513);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
